// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard/stall controller:
// FSM state encoding, the hard-wired zero register and the MDU latency default.
package hazard_pkg;

    // Controller state: normal issue, or multiply/divide unit occupied.
    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } hz_state_e;

    // $zero is hard-wired, so a load targeting it never creates a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Cycles the MDU stays busy after a start (legal range 1..15).
    localparam int DEFAULT_MDU_LATENCY = 4;

endpackage : hazard_pkg

// File: rtl/hazard_stall_controller_load_use.sv
// Load-use detector: flags an ID instruction that needs the result of a load
// still in EX. Purely combinational so it can be shared with the branch-compare
// logic in ID.
module load_use_detector
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rt_i,
    output logic       load_use_o
);

    logic rs_match;
    logic rt_match;
    logic dest_live;

    // A load into $zero produces nothing to wait for; rt only matters when read.
    always_comb begin
        dest_live  = (ex_rt_i != REG_ZERO);
        rs_match   = (ex_rt_i == id_rs_i);
        rt_match   = id_uses_rt_i && (ex_rt_i == id_rt_i);
        load_use_o = ex_mem_read_i && dest_live && (rs_match || rt_match);
    end

endmodule : load_use_detector

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the 5-stage core. Resolves the hazards
// forwarding cannot: load-use stalls, taken-branch flushes and stalls around
// the multi-cycle MDU. Control outputs are combinational so a stall or flush
// takes effect in the same cycle the hazard is visible.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | MDU idle; ID may issue a new mult/div
// MDU_BUSY | MDU computing; mdu_cnt_q counts down the remaining cycles,
//          | further MDU ops and mfhi/mflo are held in ID
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int MDU_LATENCY = DEFAULT_MDU_LATENCY,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             ID_Rs,
    input  logic [4:0]             ID_Rt,
    input  logic                   ID_UsesRt,
    input  logic                   ID_IsMdu,
    input  logic                   ID_IsMfHiLo,
    input  logic                   ID_Ex_MemRead,
    input  logic [4:0]             ID_Ex_Rt,
    input  logic                   Ex_BranchTaken,
    output logic                   PC_Write,
    output logic                   IF_ID_Write,
    output logic                   ID_Ex_Bubble,
    output logic                   IF_ID_Flush,
    output logic                   MduStart,
    output logic                   MduBusy,
    output logic [STALL_CNT_W-1:0] StallCycles
);

    localparam logic [3:0] MDU_LAT = 4'(MDU_LATENCY);

    hz_state_e              state_q, state_d;
    logic [3:0]             mdu_cnt_q, mdu_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic mdu_hazard;
    logic mdu_busy;

    load_use_detector u_load_use (
        .id_rs_i       (ID_Rs),
        .id_rt_i       (ID_Rt),
        .id_uses_rt_i  (ID_UsesRt),
        .ex_mem_read_i (ID_Ex_MemRead),
        .ex_rt_i       (ID_Ex_Rt),
        .load_use_o    (load_use)
    );

    // MDU occupancy and the HI/LO dependency it creates for the ID instruction.
    always_comb begin
        mdu_busy   = (state_q == MDU_BUSY);
        mdu_hazard = mdu_busy && (ID_IsMdu || ID_IsMfHiLo);
    end

    // Pipeline control: reset, then branch flush, then stalls, then MDU issue.
    // A taken branch wins over stalls because the ID instruction is wrong-path.
    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_Ex_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        MduStart     = 1'b0;
        if (rst) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_Ex_Bubble = 1'b1;
            IF_ID_Flush  = 1'b1;
        end else if (Ex_BranchTaken) begin
            ID_Ex_Bubble = 1'b1;
            IF_ID_Flush  = 1'b1;
        end else if (load_use || mdu_hazard) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_Ex_Bubble = 1'b1;
        end else if (ID_IsMdu && !mdu_busy) begin
            MduStart     = 1'b1;
        end
    end

    assign MduBusy = mdu_busy && !rst;

    // FSM next state: the countdown runs every busy cycle regardless of
    // stalls or flushes, since the running MDU op is older than any branch.
    always_comb begin
        state_d   = state_q;
        mdu_cnt_d = mdu_cnt_q;
        case (state_q)
            RUN: begin
                if (MduStart) begin
                    state_d   = MDU_BUSY;
                    mdu_cnt_d = MDU_LAT;
                end
            end
            MDU_BUSY: begin
                if (mdu_cnt_q == 4'd1) begin
                    state_d   = RUN;
                    mdu_cnt_d = 4'd0;
                end else begin
                    mdu_cnt_d = mdu_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d   = RUN;
                mdu_cnt_d = 4'd0;
            end
        endcase
    end

    // FSM registers; reset abandons any MDU operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            mdu_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

    // Stall counter next value: count frozen-PC cycles, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!PC_Write && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    // Stall counter register; reset cycles are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCycles = stall_cnt_q;

endmodule : hazard_stall_controller
